// File: rtl/memory_cycle.sv
// Memory stage: word load/store over a ready-based bus, stall generation,
// timeout/misalignment reporting and the M->W pipeline register.
module memory_cycle #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic        ResultSrcM,
  input  logic [4:0]  RD_M,
  input  logic [31:0] PCPlus4M,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] ALUResultM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        StallM,
  output logic        RegWriteW,
  output logic        ResultSrcW,
  output logic [4:0]  RD_W,
  output logic [31:0] PCPlus4W,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic        ErrW,
  output logic [1:0]  ErrCodeW
);

  typedef enum logic {IDLE, WAIT} state_t;
  typedef enum logic [1:0] {ACT_PASS, ACT_BUBBLE, ACT_MISALIGN, ACT_TIMEOUT} act_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state, state_next;
  logic [7:0]  cnt, cnt_next;
  act_t        act;
  logic        stall;
  logic        access;
  logic        aligned;

  assign access    = MemWriteM | ResultSrcM;
  assign aligned   = (ALUResultM[1:0] == 2'b00);

  // Bus drive is purely combinational; reset forces the request low at once.
  assign mem_req   = rst & access & aligned;
  assign mem_we    = MemWriteM;
  assign mem_addr  = ALUResultM;
  assign mem_wdata = WriteDataM;
  assign StallM    = rst & stall;

  // State and request-counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Decide what the W slot does this cycle and where the FSM goes next.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    act        = ACT_PASS;
    stall      = 1'b0;
    if (!access) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else if (!aligned) begin
      act        = ACT_MISALIGN;
      state_next = IDLE;
      cnt_next   = '0;
    end else if (mem_ready) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else if (state == WAIT && cnt == CNT_LAST) begin
      // Last permitted request cycle: drop the stall so the squash retires.
      act        = ACT_TIMEOUT;
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      act        = ACT_BUBBLE;
      stall      = 1'b1;
      state_next = WAIT;
      cnt_next   = (state == IDLE) ? 8'd1 : cnt + 8'd1;
    end
  end

  // W-stage pipeline register with squash, bubble and error reporting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= 1'b0;
      RD_W       <= '0;
      PCPlus4W   <= '0;
      ALUResultW <= '0;
      ReadDataW  <= '0;
      ErrW       <= 1'b0;
      ErrCodeW   <= 2'b00;
    end else begin
      case (act)
        ACT_PASS: begin
          RegWriteW  <= RegWriteM;
          ResultSrcW <= ResultSrcM;
          RD_W       <= RD_M;
          PCPlus4W   <= PCPlus4M;
          ALUResultW <= ALUResultM;
          ReadDataW  <= ResultSrcM ? mem_rdata : '0;
          ErrW       <= 1'b0;
          ErrCodeW   <= 2'b00;
        end
        ACT_BUBBLE: begin
          RegWriteW  <= 1'b0;
          ErrW       <= 1'b0;
          ErrCodeW   <= 2'b00;
        end
        default: begin
          RegWriteW  <= 1'b0;
          ResultSrcW <= ResultSrcM;
          RD_W       <= RD_M;
          PCPlus4W   <= PCPlus4M;
          ALUResultW <= ALUResultM;
          ReadDataW  <= '0;
          ErrW       <= 1'b1;
          ErrCodeW   <= (act == ACT_MISALIGN) ? 2'b01 : 2'b10;
        end
      endcase
    end
  end

endmodule

// File: doc/memory_cycle.md
Name: memory_cycle

Overview:
- Memory stage of the 5-stage RISC-V pipeline. Consumes the M-stage bundle produced by the execute stage (RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALUResultM).
- Performs the word load/store over a ready-based data-memory bus and drives StallM to freeze upstream stages while an access is outstanding.
- Registers the W-stage bundle for writeback, with a bounded timeout and misalignment reporting.

Parameters:
- TIMEOUT_CYCLES, 16: maximum request cycles per access before abort; legal range 2..255.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- RegWriteM  input  1  register write enable
- MemWriteM  input  1  store
- ResultSrcM  input  1  load (result from memory)
- RD_M  input  5  destination register
- PCPlus4M  input  32  PC+4
- WriteDataM  input  32  store data
- ALUResultM  input  32  effective address / ALU result
- mem_req  output  1  bus request
- mem_we  output  1  1=store, 0=load
- mem_addr  output  32  word address (ALUResultM)
- mem_wdata  output  32  store data
- mem_ready  input  1  access completes this cycle; mem_rdata valid the same cycle for loads
- mem_rdata  input  32  load data
- StallM  output  1  hold E/M pipeline registers and upstream
- RegWriteW  output  1  registered
- ResultSrcW  output  1  registered
- RD_W  output  5  registered
- PCPlus4W  output  32  registered
- ALUResultW  output  32  registered
- ReadDataW  output  32  registered load data
- ErrW  output  1  one-cycle error pulse, aligned with the squashed W slot
- ErrCodeW  output  2  01 misaligned, 10 timeout, 00 none

Behaviour:
- access = MemWriteM | ResultSrcM. aligned = (ALUResultM[1:0] == 0). Word accesses only.
- States: IDLE, WAIT. 8-bit request counter cnt.
- Reset (rst=0, asynchronous): state=IDLE, cnt=0, all W outputs 0, ErrW=0, ErrCodeW=0. mem_req and StallM are forced 0 while rst=0, including mid-access; the access is abandoned.
- Bus outputs are combinational:
  - mem_req = rst & access & aligned & (state==IDLE | state==WAIT).
  - mem_we=MemWriteM, mem_addr=ALUResultM, mem_wdata=WriteDataM.
  - While StallM=1, upstream holds the M inputs stable, so the bus stays stable.
- IDLE, no access: zero stall. Next edge W <= M bundle, ReadDataW <= 0.
- IDLE, access, misaligned: no mem_req, no stall. Next edge: squash (RegWriteW=0; other W fields take M values), ErrW=1, ErrCodeW=01.
- IDLE, access, aligned, mem_ready=1: single-cycle completion, StallM=0. Next edge W <= bundle; ReadDataW <= mem_rdata if load, else 0.
- IDLE, access, aligned, mem_ready=0: StallM=1. Next: state=WAIT, cnt=1, W <= bubble (RegWriteW=0; other W fields hold).
- WAIT, mem_ready=1: StallM=0. Next edge: complete as above, state=IDLE, cnt=0.
- WAIT, mem_ready=0, cnt<TIMEOUT_CYCLES-1: StallM=1, cnt++, W <= bubble.
- WAIT, mem_ready=0, cnt==TIMEOUT_CYCLES-1 (timeout): mem_req still 1 this cycle, StallM=0. Next edge: squash, ErrW=1, ErrCodeW=10, state=IDLE, cnt=0.
  - Total request cycles on timeout = TIMEOUT_CYCLES.
  - The memory must not complete a request after mem_req falls.
- ErrW/ErrCodeW return to 0 on the following edge unless a new error occurs.
- mem_ready is ignored when mem_req=0.
- Store completion writes no register unless RegWriteM=1; the bundle passes through unchanged.
- Back-to-back accesses: after a completion edge the next instruction is evaluated in IDLE with no dead cycle.

Test Plan:
- Reset: hold rst=0 with access inputs active -> mem_req=0, StallM=0, all W outputs 0. Release -> normal operation from IDLE.
- ALU op RegWriteM=1, RD_M=5, ALUResultM=0x1234 -> one cycle later RegWriteW=1, RD_W=5, ALUResultW=0x1234, StallM never 1.
- Load at 0x100, mem_ready asserted after 3 wait cycles with mem_rdata=0xDEADBEEF -> StallM=1 for exactly 3 cycles, mem_addr stable at 0x100, mem_we=0. W receives ReadDataW=0xDEADBEEF, ResultSrcW=1; bubbles (RegWriteW=0) during the stall.
- Store at 0x200, WriteDataM=0xCAFEF00D, mem_ready=1 same cycle -> mem_req=1, mem_we=1, mem_wdata=0xCAFEF00D for one cycle, StallM=0, next instruction enters with no bubble.
- Load at 0x102 -> mem_req stays 0, ErrW=1 for one cycle, ErrCodeW=01, RegWriteW=0.
- Load with mem_ready never asserted, TIMEOUT_CYCLES=16 -> mem_req high exactly 16 cycles, StallM high 15 cycles, then ErrCodeW=10, RegWriteW=0. Separately, assert rst=0 at wait cycle 5 -> mem_req falls immediately, state IDLE after release.
